// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core front end.
// The IF/ID record is also consumed by the decode stage.
package mips_pkg;

    // Architectural widths of the reference core
    localparam int unsigned CORE_ADDR_W = 32;
    localparam int unsigned CORE_DATA_W = 32;

    // sll $0,$0,0 -- the bubble inserted on a redirect
    localparam logic [CORE_DATA_W-1:0] NOP_INSTR = '0;

    // Byte stride between consecutive instructions
    localparam int unsigned INSTR_BYTES = 4;

    // IF/ID pipeline record
    typedef struct packed {
        logic [CORE_DATA_W-1:0] instr;
        logic [CORE_ADDR_W-1:0] next_adr;
        logic                   valid;
    } if_id_t;

    // Word index inside a power-of-two memory from a byte address
    function automatic int unsigned word_index(input logic [CORE_ADDR_W-1:0] adr,
                                               input int unsigned depth);
        return int'(adr >> 2) % depth;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-organised instruction store: combinational read, clocked write.
// Contents are deliberately not reset so a loader can fill it while the
// core is held in reset.
module instruction_memory #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [IDX_W-1:0]  WR_IDX,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [IDX_W-1:0]  RD_IDX,
    output logic [DATA_W-1:0] RD_DATA
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Loader write port
    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WR_IDX] <= WR_DATA;
        end
    end

    // Fetch read port; a same-cycle write is only seen after the edge
    assign RD_DATA = mem[RD_IDX];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC selection and the
// IF/ID pipeline register. A taken branch squashes IF/ID to a NOP bubble
// and wins over a stall; a stall freezes both PC and IF/ID.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       IMEM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              STALL,
    input  logic              BRANCH_TAKEN,
    input  logic [ADDR_W-1:0] BRANCH_TARGET,
    input  logic              MEM_WRITE,
    input  logic [ADDR_W-1:0] MEM_WR_ADR,
    input  logic [DATA_W-1:0] MEM_WR_DATA,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic [ADDR_W-1:0] NEXT_INS_ADR_OUT,
    output logic [DATA_W-1:0] CUR_INS_OUT,
    output logic              VALID_OUT
);

    localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);

    // Reset PC forced word-aligned so a misconfigured value cannot
    // produce an unaligned fetch address
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [DATA_W-1:0] BUBBLE_INSTR     = DATA_W'(NOP_INSTR);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] branch_aligned;
    logic [DATA_W-1:0] fetched;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;

    logic [DATA_W-1:0] ifid_instr;
    logic [ADDR_W-1:0] ifid_next_adr;
    logic              ifid_valid;

    // Address bits outside the memory index are ignored by design
    logic unused_adr_bits;
    assign unused_adr_bits = ^{BRANCH_TARGET[1:0], MEM_WR_ADR[1:0],
                               MEM_WR_ADR[ADDR_W-1:IDX_W+2]};

    // Upper address bits drop out so the memory wraps modulo its depth
    assign rd_idx = pc[IDX_W+1:2];
    assign wr_idx = MEM_WR_ADR[IDX_W+1:2];

    // Sequential successor wraps modulo 2^ADDR_W without any flag
    assign pc_plus4       = pc + ADDR_W'(INSTR_BYTES);
    assign branch_aligned = {BRANCH_TARGET[ADDR_W-1:2], 2'b00};

    instruction_memory #(
        .DEPTH  (IMEM_DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_imem (
        .CLK     (CLK),
        .WE      (MEM_WRITE),
        .WR_IDX  (wr_idx),
        .WR_DATA (MEM_WR_DATA),
        .RD_IDX  (rd_idx),
        .RD_DATA (fetched)
    );

    // Next-PC select: redirect beats stall beats sequential fetch
    always_comb begin
        pc_next = pc_plus4;
        if (BRANCH_TAKEN) begin
            pc_next = branch_aligned;
        end else if (STALL) begin
            pc_next = pc;
        end
    end

    // Program counter register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc <= RESET_PC_ALIGNED;
        end else begin
            pc <= pc_next;
        end
    end

    // IF/ID register: bubble on redirect, hold on stall, else capture fetch
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ifid_instr    <= BUBBLE_INSTR;
            ifid_next_adr <= '0;
            ifid_valid    <= 1'b0;
        end else if (BRANCH_TAKEN) begin
            ifid_instr    <= BUBBLE_INSTR;
            ifid_next_adr <= '0;
            ifid_valid    <= 1'b0;
        end else if (!STALL) begin
            ifid_instr    <= fetched;
            ifid_next_adr <= pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end

    assign PC_OUT           = pc;
    assign CUR_INS_OUT      = ifid_instr;
    assign NEXT_INS_ADR_OUT = ifid_next_adr;
    assign VALID_OUT        = ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a 256-word instance with reset PC 0x40
// driven from a vector table, and a 4-word instance for index wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: depth 256, reset PC 0x40
    logic        a_rst_n, a_stall, a_br, a_we;
    logic [31:0] a_tgt, a_wadr, a_wdata;
    logic [31:0] a_pc, a_nadr, a_ins;
    logic        a_v;

    // Instance B: depth 4, reset PC 0
    logic        b_rst_n, b_stall, b_br, b_we;
    logic [31:0] b_tgt, b_wadr, b_wdata;
    logic [31:0] b_pc, b_nadr, b_ins;
    logic        b_v;

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .IMEM_DEPTH(256), .RESET_PC(32'h40)) dut_a (
        .CLK(clk), .RESET_N(a_rst_n), .STALL(a_stall), .BRANCH_TAKEN(a_br),
        .BRANCH_TARGET(a_tgt), .MEM_WRITE(a_we), .MEM_WR_ADR(a_wadr),
        .MEM_WR_DATA(a_wdata), .PC_OUT(a_pc), .NEXT_INS_ADR_OUT(a_nadr),
        .CUR_INS_OUT(a_ins), .VALID_OUT(a_v)
    );

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .IMEM_DEPTH(4), .RESET_PC(32'h0)) dut_b (
        .CLK(clk), .RESET_N(b_rst_n), .STALL(b_stall), .BRANCH_TAKEN(b_br),
        .BRANCH_TARGET(b_tgt), .MEM_WRITE(b_we), .MEM_WR_ADR(b_wadr),
        .MEM_WR_DATA(b_wdata), .PC_OUT(b_pc), .NEXT_INS_ADR_OUT(b_nadr),
        .CUR_INS_OUT(b_ins), .VALID_OUT(b_v)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        we;
        logic [31:0] wadr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] nadr;
        logic        v;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] nadr;
        logic        v;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    function automatic vec_t mk(logic stall, logic br, logic [31:0] tgt,
                                logic we, logic [31:0] wadr, logic [31:0] wdata,
                                logic [31:0] pc, logic [31:0] ins,
                                logic [31:0] nadr, logic v);
        vec_t r;
        r.stall = stall; r.br = br; r.tgt = tgt;
        r.we = we; r.wadr = wadr; r.wdata = wdata;
        r.pc = pc; r.ins = ins; r.nadr = nadr; r.v = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] nadr, input logic v);
        check({tag, " pc"},   a_pc,   pc);
        check({tag, " ins"},  a_ins,  ins);
        check({tag, " nadr"}, a_nadr, nadr);
        check({tag, " valid"}, {31'b0, a_v}, {31'b0, v});
    endtask

    task automatic a_write(input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        a_we = 1'b1; a_wadr = adr; a_wdata = data;
        @(posedge clk); #1;
        a_we = 1'b0;
    endtask

    task automatic b_write(input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        b_we = 1'b1; b_wadr = adr; b_wdata = data;
        @(posedge clk); #1;
        b_we = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [31:0] b_img [4];

        a_rst_n = 1'b0; a_stall = 1'b0; a_br = 1'b0; a_we = 1'b0;
        a_tgt = '0; a_wadr = '0; a_wdata = '0;
        b_rst_n = 1'b0; b_stall = 1'b0; b_br = 1'b0; b_we = 1'b0;
        b_tgt = '0; b_wadr = '0; b_wdata = '0;

        // Memory is loaded while both cores sit in reset
        a_write(32'h40, 32'h0000_000A);
        a_write(32'h44, 32'h0000_000B);
        a_write(32'h48, 32'h0000_000C);
        a_write(32'h00, 32'h2008_0005);
        a_write(32'h04, 32'h2009_0007);
        a_write(32'h08, 32'h1111_2222);
        a_write(32'h10, 32'h0000_4444);
        a_write(32'h20, 32'h0000_8888);
        a_write(32'hFFFF_FFFC, 32'h0000_FFAA);
        b_img[0] = 32'hB000_0000; b_img[1] = 32'hB000_0001;
        b_img[2] = 32'hB000_0002; b_img[3] = 32'hB000_0003;
        for (int i = 0; i < 4; i++) b_write(32'(i * 4), b_img[i]);

        check_a("reset", 32'h40, 32'h0, 32'h0, 1'b0);
        check("b reset pc", b_pc, 32'h0);
        check("b reset valid", {31'b0, b_v}, 32'h0);

        //          stall br   tgt           we   wadr   wdata         pc            ins           nadr          v
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h44,       32'hA,        32'h44,       1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h48,       32'hB,        32'h48,       1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h4C,       32'hC,        32'h4C,       1));
        tbl.push_back(mk(0, 1, 32'h0,        0, 32'h0,  32'h0,        32'h0,        32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h4,        32'h2008_0005, 32'h4,       1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h8,        32'h2009_0007, 32'h8,       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,  32'h0,        32'h8,        32'h2009_0007, 32'h8,       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,  32'h0,        32'h8,        32'h2009_0007, 32'h8,       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,  32'h0,        32'h8,        32'h2009_0007, 32'h8,       1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'hC,        32'h1111_2222, 32'hC,       1));
        tbl.push_back(mk(1, 1, 32'h23,       0, 32'h0,  32'h0,        32'h20,       32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h24,       32'h8888,     32'h24,       1));
        tbl.push_back(mk(0, 1, 32'h10,       0, 32'h0,  32'h0,        32'h10,       32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h10, 32'h5555,     32'h14,       32'h4444,     32'h14,       1));
        tbl.push_back(mk(0, 1, 32'h10,       0, 32'h0,  32'h0,        32'h10,       32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h14,       32'h5555,     32'h14,       1));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h0,        32'hFFAA,     32'h0,        1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h4,        32'h2008_0005, 32'h4,       1));
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'h4,  32'h7777,     32'h4,        32'h2008_0005, 32'h4,       1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        32'h8,        32'h7777,     32'h8,        1));

        // Release A and drive the first vector in the same low phase
        @(negedge clk);
        a_rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            a_stall = tbl[i].stall; a_br = tbl[i].br; a_tgt = tbl[i].tgt;
            a_we = tbl[i].we; a_wadr = tbl[i].wadr; a_wdata = tbl[i].wdata;
            e.pc = tbl[i].pc; e.ins = tbl[i].ins; e.nadr = tbl[i].nadr; e.v = tbl[i].v;
            sb.push_back(e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                check($sformatf("vec%0d scoreboard empty", i), 32'h0, 32'h1);
            end else begin
                e = sb.pop_front();
                check_a($sformatf("vec%0d", i), e.pc, e.ins, e.nadr, e.v);
            end
            @(negedge clk);
        end
        a_stall = 1'b0; a_br = 1'b0; a_we = 1'b0;

        // Asynchronous reset between edges takes effect without a clock edge
        #2 a_rst_n = 1'b0;
        #1 check_a("async reset", 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(posedge clk); #1;
        check_a("post reset fetch", 32'h44, 32'hA, 32'h44, 1'b1);
        a_stall = 1'b1;

        // Depth-4 memory: index wraps while the PC keeps counting
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("b step%0d ins", k), b_ins, b_img[k % 4]);
            check($sformatf("b step%0d pc", k), b_pc, 32'((k + 1) * 4));
        end
        check("b final nadr", b_nadr, 32'h18);
        check("b final valid", {31'b0, b_v}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the pipelined MIPS core, the next generation of the fixed-width IF stage. Holds the program counter, reads a word-addressed instruction memory, and registers the fetched instruction plus its PC+4 into the IF/ID pipeline register. Adds branch redirect, pipeline stall, a bubble/valid flag, a configurable reset PC, and a loader write port into instruction memory.

## Interface
- ADDR_W, 32, PC / byte-address width
- DATA_W, 32, instruction width
- IMEM_DEPTH, 256, instruction words (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset (word-aligned)
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- STALL  in  1  hold PC and IF/ID contents
- BRANCH_TAKEN  in  1  redirect fetch to BRANCH_TARGET and squash IF/ID
- BRANCH_TARGET  in  ADDR_W  redirect byte address
- MEM_WRITE  in  1  instruction-memory write enable (program loader)
- MEM_WR_ADR  in  ADDR_W  write byte address
- MEM_WR_DATA  in  DATA_W  write data
- PC_OUT  out  ADDR_W  current PC (address now being fetched)
- NEXT_INS_ADR_OUT  out  ADDR_W  IF/ID: PC+4 of the registered instruction
- CUR_INS_OUT  out  DATA_W  IF/ID: registered instruction
- VALID_OUT  out  1  IF/ID: instruction is real (0 = bubble)

## Operation
- Memory index = addr[log2(IMEM_DEPTH)+1:2]; upper bits ignored (wrap modulo depth), addr[1:0] ignored.
- Read is combinational from PC; write is synchronous on CLK when MEM_WRITE=1.
- Per rising edge, priority high→low:
  - BRANCH_TAKEN=1: PC ← {BRANCH_TARGET[ADDR_W-1:2],2'b00}; IF/ID ← bubble (CUR_INS_OUT=0, NEXT_INS_ADR_OUT=0, VALID_OUT=0). Overrides STALL.
  - STALL=1: PC and IF/ID hold.
  - else: IF/ID ← {imem[PC], PC+4, 1}; PC ← PC+4.
- PC+4 is modulo 2^ADDR_W; wrap from all-ones region to 0 is legal, no flag.
- MEM_WRITE is independent of STALL/BRANCH_TAKEN; write to the address being fetched in the same cycle: IF/ID captures the pre-write word; new word visible from next cycle.
- Bubble encoding 0 is the MIPS NOP (sll $0,$0,0).

## Timing
- Reset (RESET_N=0, any time, immediate): PC_OUT=RESET_PC, CUR_INS_OUT=0, NEXT_INS_ADR_OUT=0, VALID_OUT=0. Instruction memory contents not reset.
- Reset mid-operation discards in-flight IF/ID contents; first edge after deassertion captures imem[RESET_PC], NEXT_INS_ADR_OUT=RESET_PC+4, VALID_OUT=1.
- Fetch latency 1 cycle: word at PC appears on CUR_INS_OUT after the next edge.
- Redirect latency: edge N with BRANCH_TAKEN → VALID_OUT=0 after N; imem[target] on CUR_INS_OUT after N+1.
- Throughput one instruction per cycle with STALL=0.
- All outputs registered except none combinational; PC_OUT is the PC register.

## Structure
- Shared package (mips_pkg): NOP_INSTR = 0, INSTR_BYTES = 4, and the IF/ID record typedef {instr, next_adr, valid} reused by the decode stage.
- Sub-module instruction_memory: parametrised DEPTH/DATA_W array, async read port, sync write port; fetch_unit owns PC, next-PC mux and IF/ID register.

## Test plan
- Reset with RESET_PC=0x40, imem[16..18]=0xA,0xB,0xC: release → after edges 1,2,3 CUR_INS_OUT=0xA,0xB,0xC, NEXT_INS_ADR_OUT=0x44,0x48,0x4C, VALID_OUT=1.
- Load via MEM_WRITE at 0x0,0x4 = 0x20080005,0x20090007, then run from 0 → CUR_INS_OUT shows both in order; write to PC's address in same cycle → old word captured, new word on refetch.
- STALL high 3 cycles at PC=0x8 → PC_OUT=0x8, IF/ID unchanged for 3 cycles, resumes with imem[2] after release.
- BRANCH_TAKEN with target 0x23 while STALL=1 → PC_OUT=0x20, next IF/ID VALID_OUT=0, CUR_INS_OUT=0; following edge CUR_INS_OUT=imem[8].
- IMEM_DEPTH=4, run from 0 for 6 cycles → CUR_INS_OUT repeats imem[0..3,0,1]; PC_OUT=0x18 (no PC wrap, index wraps).
- Assert RESET_N=0 mid-stream between edges → outputs reset immediately, no edge required.
